// File: rtl/wino_chan_accum_pkg.sv
// Shared widths, types and helpers for the Winograd channel accumulator.
package wino_chan_accum_pkg;

  localparam int unsigned ELEM_N = 16;
  localparam int unsigned PROD_W = 16;
  localparam int unsigned ACC_W  = 24;
  localparam int unsigned OUT_W  = 11;
  localparam int unsigned SH_W   = 4;
  localparam int unsigned UPV_W  = ELEM_N * OUT_W;

  typedef logic signed [ACC_W-1:0] acc_t;

  // How an accepted beat interacts with the running tile.
  typedef enum logic [1:0] {
    BEAT_ADD,
    BEAT_LOAD,
    BEAT_DROP
  } beat_kind_e;

  localparam acc_t SAT_MAX = acc_t'((1 << (OUT_W - 1)) - 1);
  localparam acc_t SAT_MIN = ~SAT_MAX;

  function automatic acc_t sext_prod(input logic [PROD_W-1:0] p);
    return acc_t'(signed'(p));
  endfunction

endpackage

// File: rtl/wino_sat_shift.sv
// One lane of output scaling: arithmetic right shift, then signed clamp to OUT_W.
module wino_sat_shift
  import wino_chan_accum_pkg::*;
(
  input  logic signed [ACC_W-1:0] sum,
  input  logic [SH_W-1:0]         shift,
  output logic [OUT_W-1:0]        res,
  output logic                    sat
);

  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    shifted = sum >>> shift;
    res     = shifted[OUT_W-1:0];
    sat     = 1'b0;
    if (shifted > SAT_MAX) begin
      res = SAT_MAX[OUT_W-1:0];
      sat = 1'b1;
    end else if (shifted < SAT_MIN) begin
      res = SAT_MIN[OUT_W-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/wino_chan_accum.sv
// Accumulates 16 per-lane products across channels, scales and saturates the tile,
// and hands it to the output transform with a valid/ready handshake.
module wino_chan_accum
  import wino_chan_accum_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_first,
  input  logic                       in_last,
  input  logic [ELEM_N*PROD_W-1:0]   in_prod,
  input  logic [SH_W-1:0]            frac_shift,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [UPV_W-1:0]           up_v,
  output logic                       sat_flag,
  output logic                       proto_err
);

  logic                    tile_open;
  logic                    out_full;
  logic signed [ACC_W-1:0] acc [ELEM_N];
  logic signed [ACC_W-1:0] sum [ELEM_N];
  logic [UPV_W-1:0]        sat_v;
  logic [ELEM_N-1:0]       lane_sat;
  logic                    accept;
  beat_kind_e              kind;

  assign in_ready  = !out_full | out_ready;
  assign out_valid = out_full;
  assign accept    = in_valid & in_ready;

  always_comb begin
    kind = BEAT_DROP;
    if (in_first)       kind = BEAT_LOAD;
    else if (tile_open) kind = BEAT_ADD;
  end

  always_comb begin
    for (int unsigned k = 0; k < ELEM_N; k++) begin
      sum[k] = ((kind == BEAT_LOAD) ? '0 : acc[k]) + sext_prod(in_prod[PROD_W*k +: PROD_W]);
    end
  end

  for (genvar g = 0; g < ELEM_N; g++) begin : g_lane
    wino_sat_shift u_sat (
      .sum   (sum[g]),
      .shift (frac_shift),
      .res   (sat_v[OUT_W*g +: OUT_W]),
      .sat   (lane_sat[g])
    );
  end

  // A completed tile may be handed off and replaced on the same edge: the clear
  // below is overridden by the load when a last beat is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tile_open <= 1'b0;
      out_full  <= 1'b0;
      up_v      <= '0;
      sat_flag  <= 1'b0;
      proto_err <= 1'b0;
      for (int unsigned k = 0; k < ELEM_N; k++) acc[k] <= '0;
    end else begin
      if (out_full && out_ready) out_full <= 1'b0;
      if (accept) begin
        if (kind == BEAT_DROP) begin
          proto_err <= 1'b1;
        end else if (in_last) begin
          up_v      <= sat_v;
          sat_flag  <= |lane_sat;
          out_full  <= 1'b1;
          tile_open <= 1'b0;
        end else begin
          for (int unsigned k = 0; k < ELEM_N; k++) acc[k] <= sum[k];
          tile_open <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wino_chan_accum.sv
// Bench for wino_chan_accum: directed table, hand-written corner sequences,
// and randomized traffic against a tile-level reference model.
module tb_wino_chan_accum;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_first, in_last, out_ready;
  logic         in_ready, out_valid, sat_flag, proto_err;
  logic [255:0] in_prod;
  logic [3:0]   frac_shift;
  logic [175:0] up_v;

  int checks = 0;
  int failures = 0;

  wino_chan_accum dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last), .in_prod(in_prod),
    .frac_shift(frac_shift), .out_valid(out_valid), .out_ready(out_ready),
    .up_v(up_v), .sat_flag(sat_flag), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v, f, l;
    int p0, p1, pr, sh;
    bit ev;
    int e0, e1, er;
    bit es, ep;
  } vec_t;

  // Reference model: keeps every beat of the open tile, sums at the end.
  int          beat_q[$];
  bit          m_open, m_full, m_sat, m_perr;
  logic [175:0] m_up;

  task automatic chk(input string nm, input logic [175:0] act, input logic [175:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [175:0] lanes(input int e0, input int e1, input int er);
    logic [175:0] v;
    logic [31:0]  x;
    for (int k = 0; k < 16; k++) begin
      x = (k == 0) ? e0 : (k == 1) ? e1 : er;
      v[11*k +: 11] = x[10:0];
    end
    return v;
  endfunction

  task automatic drive(input bit v, input bit f, input bit l, input int p0, input int p1,
                       input int pr, input int sh, input bit ordy);
    logic [31:0] x;
    logic [31:0] s;
    in_valid = v; in_first = f; in_last = l; out_ready = ordy;
    s = sh;
    frac_shift = s[3:0];
    for (int k = 0; k < 16; k++) begin
      x = (k == 0) ? p0 : (k == 1) ? p1 : pr;
      in_prod[16*k +: 16] = x[15:0];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic model_step(input bit rstn);
    bit rdy;
    int s, r;
    logic [31:0] rv;
    if (!rstn) begin
      m_open = 0; m_full = 0; m_sat = 0; m_perr = 0; m_up = '0;
      beat_q.delete();
      return;
    end
    rdy = !m_full || out_ready;
    if (m_full && out_ready) m_full = 0;
    if (in_valid && rdy) begin
      if (!in_first && !m_open) begin
        m_perr = 1;
      end else begin
        if (in_first) beat_q.delete();
        for (int k = 0; k < 16; k++) beat_q.push_back(int'($signed(in_prod[16*k +: 16])));
        if (in_last) begin
          m_sat = 0;
          for (int k = 0; k < 16; k++) begin
            s = 0;
            for (int b = 0; b < beat_q.size() / 16; b++) s += beat_q[16*b + k];
            r = s >>> int'(frac_shift);
            if (r > 1023)  begin r = 1023;  m_sat = 1; end
            if (r < -1024) begin r = -1024; m_sat = 1; end
            rv = r;
            m_up[11*k +: 11] = rv[10:0];
          end
          m_full = 1; m_open = 0;
          beat_q.delete();
        end else begin
          m_open = 1;
        end
      end
    end
  endtask

  vec_t tbl[$];

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    do_reset();

    chk("reset_out_valid", {175'd0, out_valid}, 176'd0);
    chk("reset_up_v", up_v, 176'd0);
    chk("reset_sat_proto", {174'd0, sat_flag, proto_err}, 176'd0);
    chk("reset_in_ready", {175'd0, in_ready}, 176'd1);

    // v f l  p0    p1     pr  sh  ev  e0     e1     er  es ep
    tbl.push_back('{1,1,1, 256,  256,   256, 4, 1, 16,    16,    16, 0, 0});
    tbl.push_back('{0,0,0, 0,    0,     0,   4, 0, 0,     0,     0,  0, 0});
    tbl.push_back('{1,1,0, 1000, -1000, 0,   0, 0, 0,     0,     0,  0, 0});
    tbl.push_back('{1,0,0, 1000, -1000, 0,   0, 0, 0,     0,     0,  0, 0});
    tbl.push_back('{1,0,1, 1000, -1000, 0,   0, 1, 1023,  -1024, 0,  1, 0});
    tbl.push_back('{1,1,0, 1000, -1000, 0,   2, 0, 0,     0,     0,  0, 0});
    tbl.push_back('{1,0,0, 1000, -1000, 0,   2, 0, 0,     0,     0,  0, 0});
    tbl.push_back('{1,0,1, 1000, -1000, 0,   2, 1, 750,   -750,  0,  0, 0});
    tbl.push_back('{1,1,0, 5,    5,     5,   0, 0, 0,     0,     0,  0, 0});
    tbl.push_back('{1,0,0, 5,    5,     5,   0, 0, 0,     0,     0,  0, 0});
    tbl.push_back('{1,1,0, 7,    7,     7,   0, 0, 0,     0,     0,  0, 0});
    tbl.push_back('{1,0,1, 7,    7,     7,   0, 1, 14,    14,    14, 0, 0});
    tbl.push_back('{0,0,0, 0,    0,     0,   0, 0, 0,     0,     0,  0, 0});
    tbl.push_back('{1,0,1, -9,   9,     1,   0, 1, -7,    23,    3,  0, 0});

    // Last row: a continuation beat with no open tile is dropped, so up_v keeps the
    // previous tile's value only if out_valid is clear; set ev to 0 for it.
    tbl[13].ev = 0;
    tbl[13].ep = 1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].f, tbl[i].l, tbl[i].p0, tbl[i].p1, tbl[i].pr, tbl[i].sh, 1);
      tick();
      chk($sformatf("tbl%0d_out_valid", i), {175'd0, out_valid}, {175'd0, tbl[i].ev});
      chk($sformatf("tbl%0d_proto_err", i), {175'd0, proto_err}, {175'd0, tbl[i].ep});
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_up_v", i), up_v, lanes(tbl[i].e0, tbl[i].e1, tbl[i].er));
        chk($sformatf("tbl%0d_sat", i), {175'd0, sat_flag}, {175'd0, tbl[i].es});
      end
    end

    // Back-pressure: tile A held while tile B stalls, then both flow.
    do_reset();
    drive(1, 1, 1, 10, 10, 10, 0, 0);
    tick();
    chk("bp_a_valid", {175'd0, out_valid}, 176'd1);
    drive(1, 1, 0, 1, 1, 1, 0, 0);
    #1;
    chk("bp_in_ready_low", {175'd0, in_ready}, 176'd0);
    tick(); tick();
    chk("bp_a_held_valid", {175'd0, out_valid}, 176'd1);
    chk("bp_a_held_up_v", up_v, lanes(10, 10, 10));
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_high", {175'd0, in_ready}, 176'd1);
    tick();
    chk("bp_a_taken", {175'd0, out_valid}, 176'd0);
    drive(1, 0, 0, 1, 1, 1, 0, 1); tick();
    drive(1, 0, 0, 1, 1, 1, 0, 1); tick();
    drive(1, 0, 1, 1, 1, 1, 0, 1); tick();
    chk("bp_b_valid", {175'd0, out_valid}, 176'd1);
    chk("bp_b_up_v", up_v, lanes(4, 4, 4));
    // Hand-off and new last beat on the same edge keep out_valid high.
    drive(1, 1, 1, 6, 6, 6, 1, 1); tick();
    chk("bp_reload_valid", {175'd0, out_valid}, 176'd1);
    chk("bp_reload_up_v", up_v, lanes(3, 3, 3));
    drive(0, 0, 0, 0, 0, 0, 0, 1); tick();

    // Orphan beat right after reset.
    do_reset();
    drive(1, 0, 0, 9, 9, 9, 0, 1); tick();
    chk("orphan_proto", {175'd0, proto_err}, 176'd1);
    chk("orphan_no_valid", {175'd0, out_valid}, 176'd0);
    drive(1, 1, 1, 3, 3, 3, 0, 1); tick();
    chk("orphan_next_up_v", up_v, lanes(3, 3, 3));
    chk("orphan_sticky", {175'd0, proto_err}, 176'd1);

    // Reset mid-tile discards the partial sum and the pending output.
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 1, 1, 50, 50, 50, 0, 0); tick();
    drive(1, 1, 0, 1, 1, 1, 0, 1); tick();
    drive(1, 0, 0, 1, 1, 1, 0, 1); tick();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
    rst_n = 1'b1;
    chk("rst_mid_valid", {175'd0, out_valid}, 176'd0);
    chk("rst_mid_up_v", up_v, 176'd0);
    chk("rst_mid_flags", {174'd0, sat_flag, proto_err}, 176'd0);
    drive(1, 1, 0, 1, 1, 1, 0, 1); tick();
    drive(1, 0, 1, 1, 1, 1, 0, 1); tick();
    chk("rst_mid_new_up_v", up_v, lanes(2, 2, 2));
    chk("rst_mid_new_valid", {175'd0, out_valid}, 176'd1);

    // Randomized traffic against the reference model.
    do_reset();
    model_step(0);
    for (int c = 0; c < 3000; c++) begin
      bit rst_now;
      rst_now = ($urandom_range(0, 199) == 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      in_first   = ($urandom_range(0, 5) == 0);
      in_last    = ($urandom_range(0, 3) == 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      frac_shift = 4'($urandom_range(0, 15));
      for (int k = 0; k < 16; k++) begin
        if ($urandom_range(0, 1) == 0) in_prod[16*k +: 16] = 16'($urandom);
        else in_prod[16*k +: 16] = 16'($signed($urandom_range(0, 400)) - 200);
      end
      if (beat_q.size() / 16 >= 200) in_last = 1'b1;
      rst_n = !rst_now;
      #1;
      chk("rand_in_ready", {175'd0, in_ready}, {175'd0, (!m_full || out_ready)});
      model_step(!rst_now);
      tick();
      chk("rand_out_valid", {175'd0, out_valid}, {175'd0, m_full});
      chk("rand_proto_err", {175'd0, proto_err}, {175'd0, m_perr});
      if (m_full) begin
        chk("rand_up_v", up_v, m_up);
        chk("rand_sat", {175'd0, sat_flag}, {175'd0, m_sat});
      end
    end
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
